pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline. Drives the IF_ID register's Stall_i and the flush/stall controls of the PC, IF/ID, ID/EX and EX/MEM stages.
- Arbitrates between three stall/flush sources:
  - cache wait (I-cache or D-cache),
  - EX-stage branch mispredict,
  - load-use dependency, with a configurable bubble count.
- Keeps saturating performance counters for stall cycles and mispredict flushes.

---
 rtl/pipe_hazard_ctrl.sv | 121 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush sequencer: cache wait, branch mispredict, load-use.
// Also keeps saturating stall-cycle and mispredict-flush counters.
module pipe_hazard_ctrl #(
    parameter int LU_BUBBLES = 1,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             icache_stall_i,
    input  logic             dcache_stall_i,
    input  logic             ex_mispredict_i,
    input  logic             id_ex_memread_i,
    input  logic [4:0]       id_ex_rd_i,
    input  logic [4:0]       if_id_rs1_i,
    input  logic [4:0]       if_id_rs2_i,
    input  logic             rs1_used_i,
    input  logic             rs2_used_i,
    input  logic             perf_clr_i,
    output logic             pc_write_o,
    output logic             pc_redirect_o,
    output logic             if_id_stall_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic             ex_mem_stall_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic {RUN, LU_WAIT} state_t;

    localparam logic [1:0] LU_INIT = 2'(LU_BUBBLES - 1);

    state_t     state_q, state_d;
    logic [1:0] lu_cnt_q, lu_cnt_d;
    logic       mem_stall;
    logic       lu_hit;
    logic       rd_nz;

    assign mem_stall = icache_stall_i | dcache_stall_i;
    assign rd_nz     = id_ex_rd_i != 5'd0;
    assign lu_hit    = id_ex_memread_i & rd_nz &
                       ((rs1_used_i & (id_ex_rd_i == if_id_rs1_i)) |
                        (rs2_used_i & (id_ex_rd_i == if_id_rs2_i)));

    always_comb begin
        pc_write_o     = 1'b0;
        pc_redirect_o  = 1'b0;
        if_id_stall_o  = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        ex_mem_stall_o = 1'b0;
        state_d        = state_q;
        lu_cnt_d       = lu_cnt_q;
        unique case (1'b1)
            !rst_n: begin
                state_d  = RUN;
                lu_cnt_d = 2'd0;
            end
            rst_n & mem_stall: begin
                if_id_stall_o  = 1'b1;
                ex_mem_stall_o = 1'b1;
            end
            rst_n & !mem_stall & ex_mispredict_i: begin
                // ID holds a wrong-path instruction, so any pending bubbles die here
                pc_write_o    = 1'b1;
                pc_redirect_o = 1'b1;
                if_id_flush_o = 1'b1;
                id_ex_flush_o = 1'b1;
                state_d       = RUN;
                lu_cnt_d      = 2'd0;
            end
            rst_n & !mem_stall & !ex_mispredict_i & (state_q == LU_WAIT): begin
                if_id_stall_o = 1'b1;
                id_ex_flush_o = 1'b1;
                lu_cnt_d      = lu_cnt_q - 2'd1;
                if (lu_cnt_q == 2'd1) begin
                    state_d = RUN;
                end
            end
            rst_n & !mem_stall & !ex_mispredict_i & (state_q == RUN) & lu_hit: begin
                if_id_stall_o = 1'b1;
                id_ex_flush_o = 1'b1;
                if (LU_BUBBLES > 1) begin
                    state_d  = LU_WAIT;
                    lu_cnt_d = LU_INIT;
                end
            end
            default: begin
                pc_write_o = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= RUN;
            lu_cnt_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            lu_cnt_q <= lu_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else if (perf_clr_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (if_id_stall_o && !(&stall_cnt_o)) begin
                stall_cnt_o <= stall_cnt_o + 1'b1;
            end
            if (if_id_flush_o && !(&flush_cnt_o)) begin
                flush_cnt_o <= flush_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized + directed bench for pipe_hazard_ctrl against a countdown model.
// Three instances cover 1, 3 and 2 load-use bubbles; the last has 4-bit counters.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, ic, dc, misp, mr, u1, u2, clr;
    logic [4:0] rd, rs1, rs2;

    logic [5:0]  ctl [3];
    logic [31:0] sc_a, fc_a, sc_b, fc_b;
    logic [3:0]  sc_c, fc_c;

    int n_tests = 0;
    int n_fail  = 0;

    int          bub  [3] = '{1, 3, 2};
    logic [31:0] cmax [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_000F};
    int          rem  [3];
    logic [31:0] msc  [3];
    logic [31:0] mfc  [3];

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.LU_BUBBLES(1), .CNT_W(32)) u_a (
        .clk(clk), .rst_n(rst_n), .icache_stall_i(ic), .dcache_stall_i(dc),
        .ex_mispredict_i(misp), .id_ex_memread_i(mr), .id_ex_rd_i(rd),
        .if_id_rs1_i(rs1), .if_id_rs2_i(rs2), .rs1_used_i(u1), .rs2_used_i(u2),
        .perf_clr_i(clr), .pc_write_o(ctl[0][5]), .pc_redirect_o(ctl[0][4]),
        .if_id_stall_o(ctl[0][3]), .if_id_flush_o(ctl[0][2]),
        .id_ex_flush_o(ctl[0][1]), .ex_mem_stall_o(ctl[0][0]),
        .stall_cnt_o(sc_a), .flush_cnt_o(fc_a)
    );

    pipe_hazard_ctrl #(.LU_BUBBLES(3), .CNT_W(32)) u_b (
        .clk(clk), .rst_n(rst_n), .icache_stall_i(ic), .dcache_stall_i(dc),
        .ex_mispredict_i(misp), .id_ex_memread_i(mr), .id_ex_rd_i(rd),
        .if_id_rs1_i(rs1), .if_id_rs2_i(rs2), .rs1_used_i(u1), .rs2_used_i(u2),
        .perf_clr_i(clr), .pc_write_o(ctl[1][5]), .pc_redirect_o(ctl[1][4]),
        .if_id_stall_o(ctl[1][3]), .if_id_flush_o(ctl[1][2]),
        .id_ex_flush_o(ctl[1][1]), .ex_mem_stall_o(ctl[1][0]),
        .stall_cnt_o(sc_b), .flush_cnt_o(fc_b)
    );

    pipe_hazard_ctrl #(.LU_BUBBLES(2), .CNT_W(4)) u_c (
        .clk(clk), .rst_n(rst_n), .icache_stall_i(ic), .dcache_stall_i(dc),
        .ex_mispredict_i(misp), .id_ex_memread_i(mr), .id_ex_rd_i(rd),
        .if_id_rs1_i(rs1), .if_id_rs2_i(rs2), .rs1_used_i(u1), .rs2_used_i(u2),
        .perf_clr_i(clr), .pc_write_o(ctl[2][5]), .pc_redirect_o(ctl[2][4]),
        .if_id_stall_o(ctl[2][3]), .if_id_flush_o(ctl[2][2]),
        .id_ex_flush_o(ctl[2][1]), .ex_mem_stall_o(ctl[2][0]),
        .stall_cnt_o(sc_c), .flush_cnt_o(fc_c)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] cnt_of(input int i, input bit flush);
        case (i)
            0:       return flush ? fc_a : sc_a;
            1:       return flush ? fc_b : sc_b;
            default: return flush ? {28'd0, fc_c} : {28'd0, sc_c};
        endcase
    endfunction

    // ctl bits: pc_write, redirect, if_id_stall, if_id_flush, id_ex_flush, ex_mem_stall
    task automatic step(input logic r, input logic i_c, input logic d_c,
                        input logic m, input logic ld, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2,
                        input logic a1, input logic a2, input logic c);
        logic [5:0] e;
        bit         lu;
        @(negedge clk);
        rst_n = r; ic = i_c; dc = d_c; misp = m; mr = ld; rd = d;
        rs1 = s1; rs2 = s2; u1 = a1; u2 = a2; clr = c;
        lu = ld && (d != 0) && ((a1 && d == s1) || (a2 && d == s2));
        #1;
        for (int i = 0; i < 3; i++) begin
            if (!r) begin
                e = 6'b000000;
                rem[i] = 0;
            end else if (i_c || d_c) begin
                e = 6'b001001;
            end else if (m) begin
                e = 6'b110110;
                rem[i] = 0;
            end else if (rem[i] > 0 || lu) begin
                e = 6'b001010;
                if (rem[i] > 0) rem[i]--;
                else rem[i] = bub[i] - 1;
            end else begin
                e = 6'b100000;
            end
            check($sformatf("ctl%0d", i), {26'd0, ctl[i]}, {26'd0, e});
            if (!r || c) begin
                msc[i] = 0;
                mfc[i] = 0;
            end else begin
                if (e[3] && msc[i] < cmax[i]) msc[i]++;
                if (e[2] && mfc[i] < cmax[i]) mfc[i]++;
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("stall_cnt%0d", i), cnt_of(i, 0), msc[i]);
            check($sformatf("flush_cnt%0d", i), cnt_of(i, 1), mfc[i]);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic lu_x5;
        step(1, 0, 0, 0, 1, 5, 0, 5, 0, 1, 0);
    endtask

    initial begin
        rst_n = 0; ic = 0; dc = 0; misp = 0; mr = 0; rd = 0;
        rs1 = 0; rs2 = 0; u1 = 0; u2 = 0; clr = 0;
        for (int i = 0; i < 3; i++) begin
            rem[i] = 0; msc[i] = 0; mfc[i] = 0;
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 1, 5, 5, 5, 1, 1, 0);
        idle(2);
        // single load-use hazard, then bubbles drain
        lu_x5();
        idle(4);
        // rd = x0 never stalls
        step(1, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0);
        idle(2);
        // dcache wait in the middle of the bubble train
        lu_x5();
        for (int k = 0; k < 4; k++) step(1, 0, 1, 0, 1, 5, 0, 5, 0, 1, 0);
        idle(4);
        // mispredict beats load-use
        step(1, 0, 0, 1, 1, 5, 5, 0, 1, 0, 0);
        idle(2);
        // mispredict held across an icache stall
        for (int k = 0; k < 3; k++) step(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // clear with a simultaneous stall
        step(1, 0, 0, 0, 1, 7, 7, 0, 1, 0, 1);
        idle(3);
        // reset mid bubble train
        lu_x5();
        step(0, 0, 0, 0, 1, 5, 0, 5, 0, 1, 0);
        idle(2);
        // long wait saturates the 4-bit counters
        for (int k = 0; k < 20; k++) step(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 99) >= 2,
                 $urandom_range(0, 99) < 10,
                 $urandom_range(0, 99) < 10,
                 $urandom_range(0, 99) < 10,
                 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 $urandom_range(0, 99) < 2);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
